// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction
// fetch (if_*) and the MEM stage (dm_*). Data accesses win by default; a fetch
// that has watched STARVE_MAX data grants go by wins the next contended grant.
// A flush during an outstanding fetch suppresses that fetch's ack and data.
// Optional build macro ARB_PERF_CNT_EN adds saturating stall-cycle counters
// (if_wait_cnt, dm_wait_cnt).
module mem_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WAIT_CYC   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              flush,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              stall_if,
   output logic              stall_dm,
`ifdef ARB_PERF_CNT_EN
   output logic [15:0]       if_wait_cnt,
   output logic [15:0]       dm_wait_cnt,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WCNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
   localparam int SCNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   state_t            state, state_nx;
   logic [WCNT_W-1:0] wait_cnt;
   logic [SCNT_W-1:0] starve_cnt;
   logic              kill;
   logic              done, eval, if_own, if_pend, if_eff, dm_eff;
   logic              grant_if, grant_dm;

   // Completion is the edge that ends the cycle in which mem_rdata is valid.
   assign done     = (state != IDLE) && (wait_cnt == '0);
   assign eval     = (state == IDLE) || done;
   // The fetch currently being served is not a new request at its own
   // completion edge, unless it has been killed by a flush.
   assign if_own   = (state == BUSY_IF) && !kill;
   assign if_pend  = if_req && !if_ack && !if_own;
   assign if_eff   = if_pend && !flush;
   assign dm_eff   = dm_req && !dm_ack && (state != BUSY_DM);
   assign grant_if = eval && if_eff && (!dm_eff || (starve_cnt == SCNT_W'(STARVE_MAX)));
   assign grant_dm = eval && dm_eff && !grant_if;

   assign stall_if = if_req && !if_ack;
   assign stall_dm = dm_req && !dm_ack;

   // State register.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: a grant at a completion edge starts the next access directly.
   always_comb begin
      state_nx = state;
      if (grant_if)      state_nx = BUSY_IF;
      else if (grant_dm) state_nx = BUSY_DM;
      else if (done)     state_nx = IDLE;
   end

   // Memory latency countdown, loaded on every grant.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)                              wait_cnt <= '0;
      else if (grant_if || grant_dm)           wait_cnt <= WCNT_W'(WAIT_CYC);
      else if (state != IDLE && wait_cnt != '0) wait_cnt <= wait_cnt - WCNT_W'(1);
   end

   // Memory port: one-cycle strobe, address/data captured at grant.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= grant_if || grant_dm;
         if (grant_if || grant_dm) begin
            mem_we    <= grant_dm && dm_we;
            mem_addr  <= grant_dm ? dm_addr : if_addr;
            mem_wdata <= dm_wdata;
         end
      end
   end

   // Acks and read data at completion; mem_we still describes this access.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         if_ack   <= 1'b0;
         dm_ack   <= 1'b0;
         if_rdata <= '0;
         dm_rdata <= '0;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         if (done && state == BUSY_IF && !kill && !flush) begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
         end
         if (done && state == BUSY_DM) begin
            dm_ack <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
         end
      end
   end

   // Kill flag: remembers a flush seen while a fetch is outstanding.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)                          kill <= 1'b0;
      else if (state == BUSY_IF && done)   kill <= 1'b0;
      else if (state == BUSY_IF && flush)  kill <= 1'b1;
   end

   // Starvation counter: data grants handed out while a fetch waits.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)                    starve_cnt <= '0;
      else if (!if_req || grant_if)  starve_cnt <= '0;
      else if (grant_dm && if_pend && starve_cnt != SCNT_W'(STARVE_MAX))
         starve_cnt <= starve_cnt + SCNT_W'(1);
   end

`ifdef ARB_PERF_CNT_EN
   // Saturating stall-cycle counters for performance monitoring.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         if_wait_cnt <= '0;
         dm_wait_cnt <= '0;
      end else begin
         if (stall_if && if_wait_cnt != 16'hFFFF) if_wait_cnt <= if_wait_cnt + 16'd1;
         if (stall_dm && dm_wait_cnt != 16'hFFFF) dm_wait_cnt <= dm_wait_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-accurate scenarios with a small memory
// model and per-requester queues of expected read data.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic              clk1 = 1'b0;
   logic              rst_n;
   logic              if_req, flush, dm_req, dm_we;
   logic [ADDR_W-1:0] if_addr, dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              if_ack, dm_ack, stall_if, stall_dm;
   logic [DATA_W-1:0] if_rdata, dm_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [15:0]       if_wait_cnt, dm_wait_cnt;
`endif

   always #5 clk1 = ~clk1;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(1), .STARVE_MAX(4)) dut (
      .clk1(clk1), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .flush(flush),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .stall_if(stall_if), .stall_dm(stall_dm),
`ifdef ARB_PERF_CNT_EN
      .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int total = 0;
   int bad = 0;
   logic [DATA_W-1:0] if_q[$];
   logic [DATA_W-1:0] dm_q[$];
   logic [DATA_W-1:0] last_if, last_dm, exp_v;
   int n;

   // Memory model: fixed contents plus the most recent store.
   logic              wr_vld;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
      if (a == 10'd5) return 32'hDEADBEEF;
      return {6'h2A, a, 6'h15, a};
   endfunction

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      if (wr_vld && wr_addr == a) return wr_data;
      return init_word(a);
   endfunction

   // Read data appears in the cycle after the strobe (one wait cycle).
   always @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) begin
            wr_vld  <= 1'b1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
         end else begin
            mem_rdata <= mem_word(mem_addr);
         end
      end
   end

   task automatic go();
      @(posedge clk1);
      #1;
   endtask

   task automatic look();
      @(negedge clk1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_req = 0; flush = 0; dm_req = 0; dm_we = 0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      repeat (3) go();
      look();
      total++;
      if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got en=%0b we=%0b ifa=%0b dma=%0b addr=%0h wd=%0h ifr=%0h dmr=%0h want all 0",
                  mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      go(); rst_n = 1'b1;
      look();
      last_if = '0; last_dm = '0;
   endtask

   task automatic test_fetch();
      go(); if_req = 1; if_addr = 10'd5; if_q.push_back(32'hDEADBEEF);
      look();
      total++;
      if ({stall_if, mem_en} !== 2'b10) begin bad++; $display("FAIL fetch_c0 got stall=%0b en=%0b want stall=1 en=0", stall_if, mem_en); end
      go(); look();
      total++;
      if ({mem_en, mem_we, mem_addr, stall_if} !== {1'b1, 1'b0, 10'd5, 1'b1}) begin
         bad++; $display("FAIL fetch_c1 got en=%0b we=%0b addr=%0d stall=%0b want 1 0 5 1", mem_en, mem_we, mem_addr, stall_if);
      end
      go(); look();
      total++;
      if ({if_ack, stall_if, mem_en} !== 3'b010) begin
         bad++; $display("FAIL fetch_c2 got ack=%0b stall=%0b en=%0b want 0 1 0", if_ack, stall_if, mem_en);
      end
      go(); look();
      total++;
      if ({if_ack, stall_if} !== 2'b10) begin
         bad++; $display("FAIL fetch_c3_ack got ack=%0b stall=%0b want 1 0", if_ack, stall_if);
      end
      exp_v = if_q.pop_front(); last_if = exp_v;
      total++;
      if (if_rdata !== exp_v) begin bad++; $display("FAIL fetch_rdata got %h want %h", if_rdata, exp_v); end
      go(); if_req = 0;
      look();
      total++;
      if ({if_ack, mem_en} !== 2'b00) begin bad++; $display("FAIL fetch_no_regrant got ack=%0b en=%0b want 0 0", if_ack, mem_en); end
   endtask

   task automatic test_back_to_back();
      go(); if_req = 1; if_addr = 10'd7; dm_req = 1; dm_we = 0; dm_addr = 10'd20;
      if_q.push_back(init_word(10'd7)); dm_q.push_back(init_word(10'd20));
      look();
      go(); look();
      total++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd20}) begin
         bad++; $display("FAIL b2b_dm_first got en=%0b we=%0b addr=%0d want 1 0 20", mem_en, mem_we, mem_addr);
      end
      go(); look();
      go(); look();
      total++;
      if ({dm_ack, mem_en, mem_we, mem_addr, stall_if} !== {1'b1, 1'b1, 1'b0, 10'd7, 1'b1}) begin
         bad++; $display("FAIL b2b_c3 got dmack=%0b en=%0b we=%0b addr=%0d stall_if=%0b want 1 1 0 7 1",
                         dm_ack, mem_en, mem_we, mem_addr, stall_if);
      end
      exp_v = dm_q.pop_front(); last_dm = exp_v;
      total++;
      if (dm_rdata !== exp_v) begin bad++; $display("FAIL b2b_dm_rdata got %h want %h", dm_rdata, exp_v); end
      go(); dm_req = 0;
      look();
      total++;
      if ({if_ack, dm_ack} !== 2'b00) begin bad++; $display("FAIL b2b_c4 got ifack=%0b dmack=%0b want 0 0", if_ack, dm_ack); end
      go(); look();
      total++;
      if (if_ack !== 1'b1) begin bad++; $display("FAIL b2b_if_ack_c5 got %0b want 1", if_ack); end
      exp_v = if_q.pop_front(); last_if = exp_v;
      total++;
      if (if_rdata !== exp_v) begin bad++; $display("FAIL b2b_if_rdata got %h want %h", if_rdata, exp_v); end
      go(); if_req = 0;
      look();
   endtask

   task automatic test_store();
      go(); dm_req = 1; dm_we = 1; dm_addr = 10'd30; dm_wdata = 32'h12345678;
      look();
      go(); look();
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'd30, 32'h12345678}) begin
         bad++; $display("FAIL store_c1 got en=%0b we=%0b addr=%0d wd=%h want 1 1 30 12345678", mem_en, mem_we, mem_addr, mem_wdata);
      end
      go(); look();
      total++;
      if (dm_ack !== 1'b0) begin bad++; $display("FAIL store_c2 got ack=%0b want 0", dm_ack); end
      go(); look();
      total++;
      if (dm_ack !== 1'b1) begin bad++; $display("FAIL store_ack_c3 got %0b want 1", dm_ack); end
      total++;
      if (dm_rdata !== last_dm) begin bad++; $display("FAIL store_rdata_hold got %h want %h", dm_rdata, last_dm); end
      go(); dm_req = 0; dm_we = 0; dm_wdata = '0;
      look();
   endtask

   task automatic test_starvation();
      go(); flush = 1; if_req = 1; if_addr = 10'd50; dm_req = 1; dm_we = 0; dm_addr = 10'd30;
      dm_q.push_back(32'h12345678);
      look();
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin go(); look(); n++; end while (!dm_ack && n < 10);
         total++;
         if (dm_ack !== 1'b1) begin bad++; $display("FAIL starve_dm_ack%0d got %0b want 1", k, dm_ack); end
         exp_v = dm_q.pop_front(); last_dm = exp_v;
         total++;
         if (dm_rdata !== exp_v) begin bad++; $display("FAIL starve_dm_rdata%0d got %h want %h", k, dm_rdata, exp_v); end
         go();
         if (k == 3) begin
            flush = 0; dm_addr = 10'd104;
         end else begin
            dm_addr = 10'(101 + k);
         end
         dm_q.push_back(init_word(dm_addr));
         look();
      end
      go(); look();
      total++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd50}) begin
         bad++; $display("FAIL starve_if_wins got en=%0b we=%0b addr=%0d want 1 0 50", mem_en, mem_we, mem_addr);
      end
      if_q.push_back(init_word(10'd50));
      n = 0;
      do begin go(); look(); n++; end while (!if_ack && n < 10);
      total++;
      if (if_ack !== 1'b1) begin bad++; $display("FAIL starve_if_ack got %0b want 1", if_ack); end
      exp_v = if_q.pop_front(); last_if = exp_v;
      total++;
      if (if_rdata !== exp_v) begin bad++; $display("FAIL starve_if_rdata got %h want %h", if_rdata, exp_v); end
      go(); flush = 1; if_addr = 10'd51; if_q.push_back(init_word(10'd51));
      look();
      n = 0;
      do begin go(); look(); n++; end while (!dm_ack && n < 10);
      total++;
      if (dm_ack !== 1'b1) begin bad++; $display("FAIL starve_dm104_ack got %0b want 1", dm_ack); end
      exp_v = dm_q.pop_front(); last_dm = exp_v;
      total++;
      if (dm_rdata !== exp_v) begin bad++; $display("FAIL starve_dm104_rdata got %h want %h", dm_rdata, exp_v); end
      go(); flush = 0; dm_addr = 10'd105; dm_q.push_back(init_word(10'd105));
      look();
      go(); look();
      total++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd105}) begin
         bad++; $display("FAIL starve_cleared got en=%0b we=%0b addr=%0d want 1 0 105", mem_en, mem_we, mem_addr);
      end
      n = 0;
      do begin go(); look(); n++; end while (!dm_ack && n < 10);
      total++;
      if (dm_ack !== 1'b1) begin bad++; $display("FAIL starve_dm105_ack got %0b want 1", dm_ack); end
      exp_v = dm_q.pop_front(); last_dm = exp_v;
      total++;
      if (dm_rdata !== exp_v) begin bad++; $display("FAIL starve_dm105_rdata got %h want %h", dm_rdata, exp_v); end
      go(); dm_req = 0;
      look();
      n = 0;
      do begin go(); look(); n++; end while (!if_ack && n < 10);
      total++;
      if (if_ack !== 1'b1) begin bad++; $display("FAIL starve_if51_ack got %0b want 1", if_ack); end
      exp_v = if_q.pop_front(); last_if = exp_v;
      total++;
      if (if_rdata !== exp_v) begin bad++; $display("FAIL starve_if51_rdata got %h want %h", if_rdata, exp_v); end
      go(); if_req = 0;
      look();
   endtask

   task automatic test_flush();
      go(); if_req = 1; if_addr = 10'd9;
      look();
      go(); flush = 1;
      look();
      go(); flush = 0; if_addr = 10'd40; if_q.push_back(init_word(10'd40));
      look();
      go(); look();
      total++;
      if (if_ack !== 1'b0) begin bad++; $display("FAIL flush_no_ack got %0b want 0", if_ack); end
      total++;
      if (if_rdata !== last_if) begin bad++; $display("FAIL flush_rdata_hold got %h want %h", if_rdata, last_if); end
      total++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd40}) begin
         bad++; $display("FAIL flush_regrant got en=%0b we=%0b addr=%0d want 1 0 40", mem_en, mem_we, mem_addr);
      end
      n = 0;
      do begin go(); look(); n++; end while (!if_ack && n < 10);
      total++;
      if (n !== 2) begin bad++; $display("FAIL flush_new_ack_latency got %0d cycles want 2", n); end
      exp_v = if_q.pop_front(); last_if = exp_v;
      total++;
      if (if_rdata !== exp_v) begin bad++; $display("FAIL flush_new_rdata got %h want %h", if_rdata, exp_v); end
      go(); if_req = 0;
      look();
   endtask

   task automatic test_reset_mid();
      go(); dm_req = 1; dm_we = 0; dm_addr = 10'd60;
      look();
      go(); look();
      #1; rst_n = 0; dm_req = 0;
      #1;
      total++;
      if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         bad++;
         $display("FAIL reset_mid_outputs got en=%0b we=%0b addr=%0d wd=%h ifr=%h dmr=%h want all 0",
                  mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      go(); rst_n = 1;
      look();
      for (int k = 0; k < 5; k++) begin
         go(); look();
         total++;
         if ({dm_ack, mem_en} !== 2'b00) begin
            bad++; $display("FAIL reset_mid_quiet%0d got ack=%0b en=%0b want 0 0", k, dm_ack, mem_en);
         end
      end
      go(); dm_req = 1; dm_addr = 10'd61; dm_q.push_back(init_word(10'd61));
      look();
      n = 0;
      do begin go(); look(); n++; end while (!dm_ack && n < 10);
      total++;
      if (n !== 3) begin bad++; $display("FAIL reset_mid_new_ack_latency got %0d cycles want 3", n); end
      exp_v = dm_q.pop_front();
      total++;
      if (dm_rdata !== exp_v) begin bad++; $display("FAIL reset_mid_new_rdata got %h want %h", dm_rdata, exp_v); end
      go(); dm_req = 0;
      look();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_store();
      test_starvation();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified 1024x32 program/data memory between the instruction-fetch stage and the MEM stage (LW/SW) of the 5-stage pipeline.
- Serialises accesses through a fixed-latency memory port and returns per-requester acks and read data.
- Raises stall_if/stall_dm so the pipeline interlocks.
- Supports a fetch flush for taken branches under predict-not-taken.

Parameters:
- ADDR_W, 10, memory word-address width
- DATA_W, 32, data width
- WAIT_CYC, 1, memory read latency in cycles, must be >= 1
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits, must be >= 1

Ports:
- clk1  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request
- if_addr  input  ADDR_W  fetch address (PC)
- if_ack  output  1  fetch complete, one-cycle pulse
- if_rdata  output  DATA_W  fetched instruction
- flush  input  1  taken branch; cancels fetch
- dm_req  input  1  data request
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_ack  output  1  data access complete, one-cycle pulse
- dm_rdata  output  DATA_W  load data
- stall_if  output  1  if_req && !if_ack
- stall_dm  output  1  dm_req && !dm_ack
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid WAIT_CYC cycles after the mem_en cycle

Behaviour:
- Reset (asynchronous, immediate): state = IDLE. All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata. The starvation counter and kill flag are 0. Any in-flight access is discarded and no ack follows reset release.
- States: IDLE, BUSY_IF, BUSY_DM. The wait counter is loaded with WAIT_CYC on each grant.
- Arbitration:
  - Requests are evaluated in IDLE, and on the completion edge of a BUSY state, so back-to-back grants are possible.
  - A requester's req is ignored in the cycle its own ack is high.
  - if_req is ignored in any cycle where flush = 1.
- Priority:
  - dm wins by default, because it is the older instruction.
  - If if_req is pending and starve_cnt == STARVE_MAX, if wins.
- Starvation counter:
  - Increments on each dm grant while if_req is pending (saturating at STARVE_MAX).
  - Clears on any if grant, and whenever if_req = 0.
- Grant at edge E:
  - During the following cycle C1: mem_en = 1, mem_addr and mem_we driven (mem_we = dm_we for data, 0 for fetch), mem_wdata = dm_wdata.
  - mem_en is high for exactly one cycle per access.
  - Addresses and data are registered at grant; requesters hold req, addr and data stable until ack.
- Completion:
  - mem_rdata is sampled at the end of cycle C(1+WAIT_CYC).
  - The ack pulses during C(2+WAIT_CYC), with rdata updated at the same edge.
- Stores: dm_ack follows the same timing; dm_rdata is unchanged.
- rdata registers hold their value between accesses.
- Flush:
  - In BUSY_IF, flush sets kill. At completion there is no if_ack, if_rdata is unchanged, and kill clears.
  - In BUSY_DM or IDLE, flush only masks if_req for that cycle.
  - flush never affects dm accesses.
- Simultaneous completion and new requests: the new grant is issued at the completion edge, and mem_en is high again in the ack cycle.
- Address width: addresses are not range-checked; they pass through unmodified.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - Adds outputs if_wait_cnt[15:0] and dm_wait_cnt[15:0].
  - These are saturating counts of cycles in which stall_if / stall_dm is high.
  - Both counters reset to 0.
- ARB_PERF_CNT_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYC = 1. if_req with if_addr = 5 from IDLE -> mem_en = 1, mem_addr = 5, mem_we = 0 in cycle 1. Memory returns 0xDEADBEEF in cycle 2 -> if_ack = 1 and if_rdata = 0xDEADBEEF in cycle 3. stall_if high in cycles 0-2.
- Simultaneous if_req (addr 7) and dm load (addr 20) -> dm granted first, dm_ack in cycle 3. if is granted at that edge, mem_addr = 7 in cycle 3, if_ack in cycle 5.
- dm store, addr 30, data 0x12345678 -> mem_en = 1, mem_we = 1, mem_wdata = 0x12345678 in cycle 1. dm_ack in cycle 3; dm_rdata keeps its prior value.
- STARVE_MAX = 4: dm issues a new load every ack while if_req is held -> 4 dm grants, then the 5th grant goes to if, then the counter clears.
- flush pulsed during BUSY_IF -> no if_ack and if_rdata unchanged. A new if_req at addr 40 is granted at the completion edge.
- rst_n driven low mid BUSY_DM -> all outputs 0 immediately. After release, no dm_ack appears within 5 cycles unless a new dm_req arrives.
